// File: rtl/vc_test_rand_delay_queue.sv
// FIFO whose head message is held for a pseudo-random 0..p_max_delay cycles before it is offered.
// Defining VC_TEST_RAND_DELAY_QUEUE_STATS_EN adds enqueue/dequeue statistics counters.
module vc_test_rand_delay_queue #(
  parameter int          p_msg_sz      = 8,
  parameter int          p_num_entries = 4,
  parameter int          p_max_delay   = 0,
  parameter logic [15:0] p_seed        = 16'hace1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [p_msg_sz-1:0] in_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [p_msg_sz-1:0] out_msg
`ifdef VC_TEST_RAND_DELAY_QUEUE_STATS_EN
  ,
  output logic [31:0]         stat_enq_count,
  output logic [31:0]         stat_deq_count
`endif
);

  localparam int AW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int CW = $clog2(p_num_entries) + 1;
  localparam logic [CW-1:0] LAST_PTR = CW'(p_num_entries - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(p_num_entries);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [15:0]   DLY_MOD  = 16'(p_max_delay + 1);

  typedef enum logic [1:0] {EMPTY, WAIT, SEND} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [15:0]         dly_q, dly_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [p_msg_sz-1:0] mem_q [p_num_entries];

  logic        enq;
  logic        deq;
  logic        load;
  logic [15:0] new_dly;
  logic        lfsr_fb;
  logic        unused_ptr_msb;

  assign in_rdy  = (count_q != FULL_CNT);
  assign out_val = (state_q == SEND);
  assign enq     = in_val && in_rdy;
  assign deq     = out_val && out_rdy;
  assign out_msg = mem_q[rd_ptr_q[AW-1:0]];
  assign new_dly = lfsr_q % DLY_MOD;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Pointers wrap at the queue depth, so their top bit never carries information.
  assign unused_ptr_msb = wr_ptr_q[CW-1] ^ rd_ptr_q[CW-1];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ONE_CNT;
    if (deq) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ONE_CNT;
    case ({enq, deq})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // A delay is drawn whenever a new message becomes the head of the queue.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    lfsr_d  = lfsr_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (enq) load = 1'b1;
      end
      WAIT: begin
        if (dly_q <= 16'd1) begin
          state_d = SEND;
          dly_d   = 16'd0;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end
      SEND: begin
        if (deq) begin
          if ((count_q > ONE_CNT) || enq) load = 1'b1;
          else                            state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      dly_d   = new_dly;
      lfsr_d  = {lfsr_q[14:0], lfsr_fb};
      state_d = (new_dly == 16'd0) ? SEND : WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dly_q    <= 16'd0;
      lfsr_q   <= p_seed;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dly_q    <= dly_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Storage is deliberately left unreset; out_msg is only meaningful with out_val.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= in_msg;
  end

`ifdef VC_TEST_RAND_DELAY_QUEUE_STATS_EN
  logic [31:0] stat_enq_q, stat_enq_d;
  logic [31:0] stat_deq_q, stat_deq_d;

  always_comb begin
    stat_enq_d = stat_enq_q;
    stat_deq_d = stat_deq_q;
    if (enq) stat_enq_d = stat_enq_q + 32'd1;
    if (deq) stat_deq_d = stat_deq_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_enq_q <= 32'd0;
      stat_deq_q <= 32'd0;
    end else begin
      stat_enq_q <= stat_enq_d;
      stat_deq_q <= stat_deq_d;
    end
  end

  assign stat_enq_count = stat_enq_q;
  assign stat_deq_count = stat_deq_q;
`endif

endmodule

// File: tb/tb_vc_test_rand_delay_queue.sv
// Bench for vc_test_rand_delay_queue: a zero-delay and a max-delay-3 instance checked against a
// queue model that predicts each head's release cycle from a reference LFSR.
module tb_vc_test_rand_delay_queue;

  localparam int          N    = 4;
  localparam logic [15:0] SEED = 16'hace1;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val  [2];
  logic       in_rdy  [2];
  logic [7:0] in_msg  [2];
  logic       out_val [2];
  logic       out_rdy [2];
  logic [7:0] out_msg [2];
`ifdef VC_TEST_RAND_DELAY_QUEUE_STATS_EN
  logic [31:0] st_enq [2];
  logic [31:0] st_deq [2];
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model state: message ring, head release cycle and reference LFSR per instance.
  logic [7:0]  mq [2][16];
  int          mhead [2];
  int          mcnt [2];
  logic [15:0] mlfsr [2];
  int          head_start [2];
  int          head_delay [2];
  bit          live [2];
  int          maxd [2];

  logic [7:0] rx_msg [2][64];
  int         rx_cyc [2][64];
  int         rx_n [2];
  int         enq_cyc [2][64];
  int         enq_n [2];

  bit ev, er, m_enq, m_deq, was_empty;

  logic [7:0] s32 [6];

  always #5 clk = ~clk;

  vc_test_rand_delay_queue #(.p_msg_sz(8), .p_num_entries(N), .p_max_delay(0), .p_seed(SEED)) dut0 (
    .clk(clk), .reset(reset),
    .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_msg(in_msg[0]),
    .out_val(out_val[0]), .out_rdy(out_rdy[0]), .out_msg(out_msg[0])
`ifdef VC_TEST_RAND_DELAY_QUEUE_STATS_EN
    , .stat_enq_count(st_enq[0]), .stat_deq_count(st_deq[0])
`endif
  );

  vc_test_rand_delay_queue #(.p_msg_sz(8), .p_num_entries(N), .p_max_delay(3), .p_seed(SEED)) dut1 (
    .clk(clk), .reset(reset),
    .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_msg(in_msg[1]),
    .out_val(out_val[1]), .out_rdy(out_rdy[1]), .out_msg(out_msg[1])
`ifdef VC_TEST_RAND_DELAY_QUEUE_STATS_EN
    , .stat_enq_count(st_enq[1]), .stat_deq_count(st_deq[1])
`endif
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare against the model, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (live[i]) begin
        ev = (mcnt[i] > 0) && (cyc >= head_start[i] + head_delay[i]);
        er = (mcnt[i] < N);
        check_output($sformatf("in_rdy%0d@%0d", i, cyc), {31'd0, in_rdy[i]}, {31'd0, er});
        check_output($sformatf("out_val%0d@%0d", i, cyc), {31'd0, out_val[i]}, {31'd0, ev});
        if (ev) check_output($sformatf("out_msg%0d@%0d", i, cyc), {24'd0, out_msg[i]}, {24'd0, mq[i][mhead[i]]});
      end
      if (reset) begin
        live[i]  = 1'b1;
        mcnt[i]  = 0;
        mhead[i] = 0;
        mlfsr[i] = SEED;
      end else if (live[i]) begin
        if (in_val[i] && in_rdy[i] && enq_n[i] < 64) begin
          enq_cyc[i][enq_n[i]] = cyc;
          enq_n[i]++;
        end
        if (out_val[i] && out_rdy[i] && rx_n[i] < 64) begin
          rx_msg[i][rx_n[i]] = out_msg[i];
          rx_cyc[i][rx_n[i]] = cyc;
          rx_n[i]++;
        end
        m_enq     = in_val[i] && er;
        m_deq     = ev && out_rdy[i];
        was_empty = (mcnt[i] == 0);
        if (m_enq) mq[i][(mhead[i] + mcnt[i]) % 16] = in_msg[i];
        if (m_deq) begin
          mhead[i] = (mhead[i] + 1) % 16;
          mcnt[i]--;
        end
        if (m_enq) mcnt[i]++;
        if ((m_enq && was_empty) || (m_deq && mcnt[i] > 0)) begin
          head_start[i] = cyc + 1;
          head_delay[i] = int'(mlfsr[i] % 16'(maxd[i] + 1));
          mlfsr[i]      = lfsr_step(mlfsr[i]);
        end
      end
    end
    cyc++;
  end

  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int i, input logic [7:0] m);
    bit got;
    got       = 1'b0;
    in_val[i] = 1'b1;
    in_msg[i] = m;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = in_rdy[i];
      @(posedge clk);
      #1;
    end
    in_val[i] = 1'b0;
    if (!got) check_output($sformatf("accept_timeout%0d_%0h", i, m), {31'd0, got}, 32'd1);
  endtask

  task automatic wait_rx(input int i, input int n, input int budget);
    for (int k = 0; k < budget && rx_n[i] < n; k++) next_cycle(1);
    check_output($sformatf("rx_count%0d", i), rx_n[i], n);
  endtask

  task automatic clear_logs(input int i);
    rx_n[i]  = 0;
    enq_n[i] = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    s32 = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    maxd[0] = 0;
    maxd[1] = 3;
    for (int i = 0; i < 2; i++) begin
      in_val[i]  = 1'b0;
      in_msg[i]  = 8'h00;
      out_rdy[i] = 1'b0;
      live[i]    = 1'b0;
      clear_logs(i);
    end
    reset = 1'b1;
    next_cycle(2);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("reset_out_val%0d", i), {31'd0, out_val[i]}, 32'd0);
      check_output($sformatf("reset_in_rdy%0d", i), {31'd0, in_rdy[i]}, 32'd1);
    end
    next_cycle(1);
    reset = 1'b0;

    $display("[TB] back-to-back stream, zero delay");
    out_rdy[0] = 1'b1;
    clear_logs(0);
    for (int k = 0; k < 6; k++) apply_stimulus(0, s32[k]);
    wait_rx(0, 6, 40);
    for (int k = 0; k < 6; k++) begin
      check_output($sformatf("b2b_msg%0d", k), {24'd0, rx_msg[0][k]}, {24'd0, s32[k]});
      check_output($sformatf("b2b_cyc%0d", k), rx_cyc[0][k], enq_cyc[0][0] + 1 + k);
    end
`ifdef VC_TEST_RAND_DELAY_QUEUE_STATS_EN
    check_output("stat_enq", st_enq[0], 32'd6);
    check_output("stat_deq", st_deq[0], 32'd6);
`endif

    $display("[TB] fill to full with sink stalled");
    out_rdy[0] = 1'b0;
    next_cycle(2);
    clear_logs(0);
    apply_stimulus(0, 8'h11);
    apply_stimulus(0, 8'h22);
    apply_stimulus(0, 8'h33);
    apply_stimulus(0, 8'h44);
    in_val[0] = 1'b1;
    in_msg[0] = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output($sformatf("full_in_rdy%0d", k), {31'd0, in_rdy[0]}, 32'd0);
      next_cycle(1);
    end
    check_output("full_enq_count", enq_n[0], 4);
    out_rdy[0] = 1'b1;
    apply_stimulus(0, 8'h55);
    wait_rx(0, 5, 40);
    for (int k = 0; k < 5; k++)
      check_output($sformatf("full_order%0d", k), {24'd0, rx_msg[0][k]}, 32'h11 * (k + 1));

    $display("[TB] hold under backpressure");
    out_rdy[0] = 1'b0;
    apply_stimulus(0, 8'ha5);
    for (int k = 0; k < 10 && !out_val[0]; k++) next_cycle(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output($sformatf("hold_val%0d", k), {31'd0, out_val[0]}, 32'd1);
      check_output($sformatf("hold_msg%0d", k), {24'd0, out_msg[0]}, 32'ha5);
      next_cycle(1);
    end
    out_rdy[0] = 1'b1;
    next_cycle(3);

    $display("[TB] random delays, 32 messages");
    out_rdy[1] = 1'b1;
    clear_logs(1);
    for (int k = 0; k < 32; k++) apply_stimulus(1, 8'(k));
    wait_rx(1, 32, 400);
    for (int k = 0; k < 32; k++)
      check_output($sformatf("rand_order%0d", k), {24'd0, rx_msg[1][k]}, k);
    // Seed ace1 yields delays 1, 3, 3 for the first three heads.
    check_output("rand_first_cyc", rx_cyc[1][0], enq_cyc[1][0] + 2);
    check_output("rand_second_cyc", rx_cyc[1][1], enq_cyc[1][0] + 6);
    check_output("rand_third_cyc", rx_cyc[1][2], enq_cyc[1][0] + 10);

    $display("[TB] reset with entries queued");
    out_rdy[0] = 1'b0;
    apply_stimulus(0, 8'hc1);
    apply_stimulus(0, 8'hc2);
    apply_stimulus(0, 8'hc3);
    reset = 1'b1;
    next_cycle(1);
    @(negedge clk);
    check_output("midreset_out_val", {31'd0, out_val[0]}, 32'd0);
    check_output("midreset_in_rdy", {31'd0, in_rdy[0]}, 32'd1);
`ifdef VC_TEST_RAND_DELAY_QUEUE_STATS_EN
    check_output("stat_enq_reset", st_enq[0], 32'd0);
    check_output("stat_deq_reset", st_deq[0], 32'd0);
`endif
    next_cycle(1);
    reset = 1'b0;
    clear_logs(0);
    out_rdy[0] = 1'b1;
    next_cycle(3);
    apply_stimulus(0, 8'h77);
    wait_rx(0, 1, 20);
    next_cycle(8);
    check_output("post_reset_rx_count", rx_n[0], 1);
    check_output("post_reset_first", {24'd0, rx_msg[0][0]}, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
